// File: rtl/internal_framebuffer_loader.sv
// Loads the internal framebuffer RAM from external memory: one read request, then stream beats into RAM.
// Optional: INTERNAL_FRAMEBUFFER_LOADER_TLAST_CHECK_EN flags tlast/length mismatches on loadError.
module internal_framebuffer_loader #(
    parameter int NUMBER_OF_PIXELS_PER_BEAT    = 1,
    parameter int NUMBER_OF_SUB_PIXELS         = 4,
    parameter int SUB_PIXEL_WIDTH              = 8,
    parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int FB_SIZE_IN_PIXEL_LG          = 20,
    parameter int ADDR_WIDTH                   = 32,
    localparam int PIXEL_WIDTH    = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int STREAM_WIDTH   = NUMBER_OF_PIXELS_PER_BEAT * PIXEL_WIDTH,
    localparam int STRB_WIDTH     = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
    localparam int MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - $clog2(NUMBER_OF_PIXELS_PER_BEAT)
) (
    input  logic                            aclk,
    input  logic                            resetn,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
    input  logic                            apply,
    output logic                            applied,
    input  logic                            cmdLoad,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,
    input  logic [ADDR_WIDTH-1:0]           cmdAddr,
    output logic                            m_avalid,
    output logic [ADDR_WIDTH-1:0]           m_aaddr,
    output logic [ADDR_WIDTH-1:0]           m_abytes,
    input  logic                            m_aready,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]         s_axis_tdata,
    input  logic [STRB_WIDTH-1:0]           s_axis_tstrb,
    output logic [STREAM_WIDTH-1:0]         writeDataPort,
    output logic                            writeEnablePort,
    output logic [MEM_ADDR_WIDTH-1:0]       writeAddrPort,
    output logic [STRB_WIDTH-1:0]           writeMaskPort,
    output logic                            loadError
);
    localparam int PPB     = NUMBER_OF_PIXELS_PER_BEAT;
    localparam int PPB_LG  = $clog2(PPB);
    localparam int CNT_W   = FB_SIZE_IN_PIXEL_LG + 1;
    localparam int BYTES_W = FB_SIZE_IN_PIXEL_LG + $clog2(PIXEL_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, REQUEST, STREAM} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          beat_cnt;
    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic                      done_q;
    logic                      start, beat_acc, beat_final;
    logic [CNT_W-1:0]          beats_total;
    logic [BYTES_W-1:0]        size_bits;

    assign start         = (state == IDLE) && applied && apply && cmdLoad && (cmdSize != '0);
    assign s_axis_tready = (state == STREAM);
    assign m_avalid      = (state == REQUEST);
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign beat_final    = beat_acc && (s_axis_tlast || (beat_cnt == CNT_W'(1)));
    assign beats_total   = (CNT_W'(cmdSize) + CNT_W'(PPB - 1)) >> PPB_LG;
    assign size_bits     = BYTES_W'(cmdSize) * BYTES_W'(PIXEL_WIDTH);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = REQUEST;
            REQUEST: if (m_aready)   state_nxt = STREAM;
            STREAM:  if (beat_final) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            applied         <= 1'b1;
            done_q          <= 1'b0;
            m_aaddr         <= '0;
            m_abytes        <= '0;
            beat_cnt        <= '0;
            word_idx        <= '0;
            writeEnablePort <= 1'b0;
            writeDataPort   <= '0;
            writeAddrPort   <= '0;
            writeMaskPort   <= '0;
        end else begin
            writeEnablePort <= beat_acc;
            // applied trails the final RAM write by one cycle
            done_q          <= beat_final;
            if (done_q) applied <= 1'b1;
            if (start) begin
                applied  <= 1'b0;
                m_aaddr  <= cmdAddr;
                m_abytes <= ADDR_WIDTH'(size_bits >> 3);
                beat_cnt <= beats_total;
                word_idx <= '0;
            end
            if (beat_acc) begin
                writeDataPort <= s_axis_tdata;
                writeMaskPort <= s_axis_tstrb & {PPB{confMask}};
                writeAddrPort <= word_idx;
                word_idx      <= word_idx + 1'b1;
                beat_cnt      <= beat_cnt - 1'b1;
            end
        end
    end

`ifdef INTERNAL_FRAMEBUFFER_LOADER_TLAST_CHECK_EN
    // tlast must coincide exactly with the counter's final beat
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn)
            loadError <= 1'b0;
        else if (start)
            loadError <= 1'b0;
        else if (beat_acc && (s_axis_tlast != (beat_cnt == CNT_W'(1))))
            loadError <= 1'b1;
    end
`else
    assign loadError = 1'b0;
`endif

endmodule
